// File: rtl/regfile_write_arbiter_if.sv
// Bundle of writeback, I/O and regfile-write signals for regfile_write_arbiter.
// slave = arbiter side, master = pipeline / I/O / regfile side.
interface regfile_write_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          wb_writeEn;
  logic [4:0]                    wb_writeReg;
  logic [31:0]                   wb_data;
  logic                          io_valid;
  logic [4:0]                    io_writeReg;
  logic [31:0]                   io_data;
  logic                          io_ready;
  logic                          ctrl_writeEn;
  logic [4:0]                    ctrl_writeReg;
  logic [31:0]                   data_writeReg;
  logic                          stall_pipe;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport slave (
    input  wb_writeEn, wb_writeReg, wb_data, io_valid, io_writeReg, io_data,
    output io_ready, ctrl_writeEn, ctrl_writeReg, data_writeReg, stall_pipe, fifo_count
  );

  modport master (
    output wb_writeEn, wb_writeReg, wb_data, io_valid, io_writeReg, io_data,
    input  io_ready, ctrl_writeEn, ctrl_writeReg, data_writeReg, stall_pipe, fifo_count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Merges writeback and queued I/O writes onto the single regfile write port.
// Writeback always wins; I/O drains in idle cycles, starvation raises stall_pipe.
module regfile_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic                    clock,
  input logic                    ctrl_reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } io_wr_t;

  io_wr_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    starve_q, starve_d;
  logic          stall_q, stall_d;
  logic          empty, full, push, pop;
  logic          we;
  logic [4:0]    wreg;
  logic [31:0]   wdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  // r0 writes complete the handshake but are dropped.
  assign push  = bus.io_valid && !full && (bus.io_writeReg != 5'd0);
  assign pop   = !bus.wb_writeEn && !empty;

  always_comb begin
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    count_d  = count_q + CW'(push) - CW'(pop);
    stall_d  = 1'b0;
    starve_d = starve_q;
    if (empty || pop) begin
      starve_d = '0;
    end else if (starve_q == 8'(STARVE_LIMIT)) begin
      stall_d  = 1'b1;
      starve_d = '0;
    end else begin
      starve_d = starve_q + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= '{rd: bus.io_writeReg, data: bus.io_data};
  end

  always_comb begin
    we    = 1'b0;
    wreg  = '0;
    wdata = '0;
    if (!ctrl_reset) begin
      if (bus.wb_writeEn) begin
        we    = 1'b1;
        wreg  = bus.wb_writeReg;
        wdata = bus.wb_data;
      end else if (!empty) begin
        we    = 1'b1;
        wreg  = mem_q[rd_ptr_q].rd;
        wdata = mem_q[rd_ptr_q].data;
      end
    end
  end

  assign bus.ctrl_writeEn  = we;
  assign bus.ctrl_writeReg = wreg;
  assign bus.data_writeReg = wdata;
  assign bus.io_ready      = !full;
  assign bus.stall_pipe    = stall_q;
  assign bus.fifo_count    = count_q;
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Sits directly upstream of the regfile's single write port and merges two write sources onto it: the processor writeback stage and an external I/O event source (controller buttons, game timers) that deposits values into architectural registers. I/O writes are buffered in a small FIFO and drained only in cycles where writeback is idle. A starvation counter raises a pipeline-stall request so queued I/O writes cannot wait forever. Output drives `ctrl_writeEn`, `ctrl_writeReg` and `data_writeReg` of the regfile.

## Interface
- `FIFO_DEPTH`, 4: I/O write queue entries; power of two, 2..16.
- `STARVE_LIMIT`, 8: cycles a non-empty FIFO head may wait before `stall_pipe` asserts; 1..255.

- `clock` in 1: single clock; all state updates on posedge.
- `ctrl_reset` in 1: asynchronous, active-high reset.
- `wb_writeEn` in 1: writeback write request, valid this cycle.
- `wb_writeReg` in 5: writeback destination register.
- `wb_data` in 32: writeback data.
- `io_valid` in 1: I/O source offers a write.
- `io_writeReg` in 5: I/O destination register.
- `io_data` in 32: I/O data.
- `io_ready` out 1: FIFO can accept; transfer occurs on posedge when `io_valid && io_ready`.
- `ctrl_writeEn` out 1: to regfile.
- `ctrl_writeReg` out 5: to regfile.
- `data_writeReg` out 32: to regfile.
- `stall_pipe` out 1: registered request for pipeline to hold writeback for one cycle.
- `fifo_count` out clog2(FIFO_DEPTH)+1: current occupancy.

## Operation
- FIFO: circular buffer, read/write pointers wrap modulo FIFO_DEPTH; `io_ready = (fifo_count != FIFO_DEPTH)`. No full-FIFO pass-through: when full, `io_ready`=0 even if a pop occurs the same cycle.
- I/O writes with `io_writeReg == 0` are accepted (handshake completes) but not enqueued; count unchanged.
- Output mux (combinational): if `wb_writeEn`, drive wb fields; else if FIFO non-empty, drive FIFO head and pop on next posedge; else `ctrl_writeEn`=0, `ctrl_writeReg`=0, `data_writeReg`=0.
- Writeback always wins. Same-register collision (wb and head target same reg): wb written this cycle, head stays queued and overwrites later; this ordering is intended.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Starvation counter: increments each cycle FIFO is non-empty and no pop occurs; clears on pop or when FIFO empty. When counter reaches STARVE_LIMIT, `stall_pipe` registers high for exactly one cycle and counter clears.
- While `stall_pipe`=1 the pipeline must deassert `wb_writeEn`; if it does not, wb still wins and the counter restarts from 0.
- `ctrl_reset` high: `ctrl_writeEn` forced 0 combinationally regardless of `wb_writeEn`.

## Timing
- Reset values: FIFO empty, pointers 0, `fifo_count`=0, starvation counter 0, `stall_pipe`=0, `io_ready`=1, `ctrl_writeEn`=0, `ctrl_writeReg`=0, `data_writeReg`=0.
- Reset mid-operation: queued entries discarded immediately (asynchronous); no partial write issued.
- Writeback latency: 0 cycles (same-cycle combinational pass-through to regfile).
- I/O latency: minimum 1 cycle (accepted at posedge N, earliest regfile write at posedge N+1); no empty-FIFO bypass.
- Drain rate: at most one FIFO entry per cycle.
- `stall_pipe` rises the cycle after the counter reaches STARVE_LIMIT; with continuous wb, head is written no later than STARVE_LIMIT+2 cycles after reaching the head.
- `fifo_count` and `io_ready` update on posedge only.

## Test plan
- Reset then idle, no requests -> all outputs 0 except `io_ready`=1; `fifo_count`=0 for 10 cycles.
- wb only: `wb_writeEn`=1, reg 5, data 0xDEADBEEF -> same cycle `ctrl_writeEn`=1, reg 5, data 0xDEADBEEF; FIFO untouched.
- I/O fill: 5 back-to-back `io_valid` (regs 1..5, data 10..50) with wb busy and STARVE_LIMIT large -> first 4 accepted, `fifo_count`=4, `io_ready`=0, 5th held; wb idles -> writes regs 1,2,3,4 in order one per cycle, then reg 5 accepted and written.
- Collision: head reg 7 data 100, wb reg 7 data 200 same cycle -> reg 7 gets 200, next idle cycle gets 100.
- Starvation: one queued entry, wb held high continuously, STARVE_LIMIT=8 -> `stall_pipe` high exactly one cycle after 8 waiting cycles; bench drops wb then -> entry written that cycle, counter 0.
- Reset mid-drain with `fifo_count`=3 -> immediate `fifo_count`=0, `ctrl_writeEn`=0; after release no stale entries written; r0 I/O write accepted but `fifo_count` stays 0.
